// File: rtl/cla8_seq_adder.sv
// cla8_seq_adder: multi-cycle wide adder built around one 8-bit carry-lookahead
// adder, which is reused NBYTES times, low byte first.
//
// Ports:
//   clk      - system clock, rising edge
//   reset_n  - asynchronous active-low reset
//   start    - request; sampled only while idle
//   a, b, ci - operands and carry-in, captured on the accepted start edge
//   busy     - high while an add is in flight and during the done cycle
//   done     - one-cycle pulse, s/co valid
//   s, co    - registered sum and final carry-out; held until the next start
//
// Also contains cla8, the 8-bit carry-lookahead adder slice.

// cla8: 8-bit adder with every carry computed directly from generate/propagate
// terms (no ripple through the lower carries).
//   a, b - addends; ci - carry-in; s - sum; co - carry-out
module cla8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       ci,
    output logic [7:0] s,
    output logic       co
);

    logic [7:0] g;
    logic [7:0] p;
    logic [8:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // c[i+1] = OR_j ( g[j] & p[j+1..i] ) | ( ci & p[0..i] )
    always_comb begin
        logic prod;
        logic c_next;
        c      = '0;
        c[0]   = ci;
        prod   = 1'b0;
        c_next = 1'b0;
        for (int i = 0; i < 8; i++) begin
            c_next = 1'b0;
            for (int j = 0; j <= i; j++) begin
                prod = g[j];
                for (int k = j + 1; k <= i; k++) begin
                    prod = prod & p[k];
                end
                c_next = c_next | prod;
            end
            prod = ci;
            for (int k = 0; k <= i; k++) begin
                prod = prod & p[k];
            end
            c_next   = c_next | prod;
            c[i + 1] = c_next;
        end
    end

    assign s  = p ^ c[7:0];
    assign co = c[8];

endmodule

module cla8_seq_adder #(
    parameter int unsigned NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [8*NBYTES-1:0]   a,
    input  logic [8*NBYTES-1:0]   b,
    input  logic                  ci,
    output logic                  busy,
    output logic                  done,
    output logic [8*NBYTES-1:0]   s,
    output logic                  co
);

    localparam int unsigned W     = 8 * NBYTES;
    localparam int unsigned IDX_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q,   idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     la_q,    la_d;
    logic [W-1:0]     lb_q,    lb_d;
    logic [W-1:0]     s_q,     s_d;
    logic             co_q,    co_d;
    logic             busy_q,  busy_d;
    logic             done_q,  done_d;

    logic [W-1:0]     a_shift;
    logic [W-1:0]     b_shift;
    logic [7:0]       slice_a;
    logic [7:0]       slice_b;
    logic [7:0]       slice_s;
    logic             slice_co;

    // Current byte of the latched operands, selected by idx
    assign a_shift = la_q >> {idx_q, 3'b000};
    assign b_shift = lb_q >> {idx_q, 3'b000};
    assign slice_a = a_shift[7:0];
    assign slice_b = b_shift[7:0];

    cla8 u_cla8 (
        .a  (slice_a),
        .b  (slice_b),
        .ci (carry_q),
        .s  (slice_s),
        .co (slice_co)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            la_q    <= '0;
            lb_q    <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            la_q    <= la_d;
            lb_q    <= lb_d;
            s_q     <= s_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, byte sequencing and registered status flags
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        la_d    = la_q;
        lb_d    = lb_q;
        s_d     = s_q;
        co_d    = co_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    la_d    = a;
                    lb_d    = b;
                    carry_d = ci;
                    idx_d   = '0;
                    s_d     = '0;
                    co_d    = 1'b0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int unsigned k = 0; k < NBYTES; k++) begin
                    if (IDX_W'(k) == idx_q) begin
                        s_d[8*k +: 8] = slice_s;
                    end
                end
                carry_d = slice_co;
                if (idx_q == IDX_LAST) begin
                    co_d    = slice_co;
                    idx_d   = '0;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Flags follow the state being entered so they stay registered
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_cla8_seq_adder.sv
// Directed bench for cla8_seq_adder with NBYTES=4: latency, carry chain,
// start handling, back-to-back operation and asynchronous reset abort.
module tb_cla8_seq_adder;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a_i;
    logic [31:0] b_i;
    logic        ci_i;
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        co;

    int n_cmp;
    int n_err;
    int cyc;

    cla8_seq_adder #(.NBYTES(4)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a_i),
        .b       (b_i),
        .ci      (ci_i),
        .busy    (busy),
        .done    (done),
        .s       (s),
        .co      (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One complete add: start accepted at the next edge, operands scrambled
    // afterwards, latency / busy / result / hold all checked.
    task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                         input logic civ, input logic [31:0] es, input logic eco);
        int lat;
        a_i   = av;
        b_i   = bv;
        ci_i  = civ;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_i   = $urandom;
        b_i   = $urandom;
        ci_i  = 1'b1;
        check({tag, "_busy_e0"}, 64'(busy), 64'd1);
        check({tag, "_s_clear"}, 64'(s), 64'd0);
        lat = 0;
        while (!done && lat < 20) begin
            tick();
            lat++;
            check({tag, "_busy_run"}, 64'(busy), 64'd1);
        end
        check({tag, "_latency"}, 64'(lat), 64'd4);
        check({tag, "_s"}, 64'(s), 64'(es));
        check({tag, "_co"}, 64'(co), 64'(eco));
        tick();
        check({tag, "_done_drop"}, 64'(done), 64'd0);
        check({tag, "_busy_drop"}, 64'(busy), 64'd0);
        check({tag, "_s_hold"}, 64'(s), 64'(es));
        check({tag, "_co_hold"}, 64'(co), 64'(eco));
    endtask

    initial begin
        int done_cnt;
        int t_done [3];
        logic [31:0] exp_s [3];
        logic        exp_co [3];
        logic [31:0] op_a [3];
        logic [31:0] op_b [3];
        logic        op_c [3];

        n_cmp   = 0;
        n_err   = 0;
        cyc     = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        a_i     = '0;
        b_i     = '0;
        ci_i    = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_s", 64'(s), 64'd0);
        check("rst_co", 64'(co), 64'd0);
        #3 reset_n = 1'b1;
        tick();
        check("idle_busy", 64'(busy), 64'd0);

        // Zero add, latency and busy length
        do_op("zero", 32'h0000_0000, 32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0);

        // Full carry propagation and inter-byte carry
        do_op("wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        do_op("byte_carry", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0);
        do_op("ci_only", 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1);
        do_op("max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 1'b1);
        do_op("pattern", 32'h5555_5555, 32'h2B2B_2B2B, 1'b1, 32'h8080_8081, 1'b0);

        // Start pulses during RUN and DONE are ignored
        a_i   = 32'h1234_5678;
        b_i   = 32'h1111_1111;
        ci_i  = 1'b0;
        start = 1'b1;
        tick();                                   // E0 accepted
        start = 1'b0;
        a_i   = 32'hDEAD_BEEF;
        b_i   = 32'hCAFE_F00D;
        tick();                                   // E1
        start = 1'b1;
        tick();                                   // E2: start in RUN
        start = 1'b0;
        a_i   = 32'h0F0F_0F0F;
        tick();                                   // E3
        tick();                                   // E4: DONE
        check("ign_done", 64'(done), 64'd1);
        check("ign_s", 64'(s), 64'h2345_6789);
        check("ign_co", 64'(co), 64'd0);
        start = 1'b1;
        tick();                                   // E5: start in DONE
        start = 1'b0;
        check("ign_idle_busy", 64'(busy), 64'd0);
        tick();
        check("ign_no_reaccept", 64'(busy), 64'd0);
        check("ign_no_second_done", 64'(done), 64'd0);
        check("ign_s_hold", 64'(s), 64'h2345_6789);

        // start held high: three back-to-back operations
        op_a[0] = 32'h7FFF_FFFF; op_b[0] = 32'h0000_0001; op_c[0] = 1'b0;
        exp_s[0] = 32'h8000_0000; exp_co[0] = 1'b0;
        op_a[1] = 32'h8000_0000; op_b[1] = 32'h8000_0000; op_c[1] = 1'b1;
        exp_s[1] = 32'h0000_0001; exp_co[1] = 1'b1;
        op_a[2] = 32'h0000_FFFF; op_b[2] = 32'h0000_FFFF; op_c[2] = 1'b1;
        exp_s[2] = 32'h0001_FFFF; exp_co[2] = 1'b0;
        start    = 1'b1;
        done_cnt = 0;
        for (int k = 0; k < 3; k++) begin
            a_i  = op_a[k];
            b_i  = op_b[k];
            ci_i = op_c[k];
            tick();                               // accepted
            check("b2b_clear", 64'(s), 64'd0);
            for (int w = 0; w < 4; w++) tick();
            check("b2b_done", 64'(done), 64'd1);
            if (done) begin
                t_done[done_cnt] = cyc;
                done_cnt++;
            end
            check("b2b_s", 64'(s), 64'(exp_s[k]));
            check("b2b_co", 64'(co), 64'(exp_co[k]));
            tick();                               // back in IDLE
            check("b2b_s_stable", 64'(s), 64'(exp_s[k]));
            check("b2b_co_stable", 64'(co), 64'(exp_co[k]));
        end
        start = 1'b0;
        check("b2b_done_count", 64'(done_cnt), 64'd3);
        if (done_cnt == 3) begin
            check("b2b_spacing0", 64'(t_done[1] - t_done[0]), 64'd6);
            check("b2b_spacing1", 64'(t_done[2] - t_done[1]), 64'd6);
        end
        tick();

        // Asynchronous reset during RUN at idx=2
        a_i   = 32'h0102_0304;
        b_i   = 32'h1020_3040;
        ci_i  = 1'b0;
        start = 1'b1;
        tick();                                   // E0: idx=0
        start = 1'b0;
        tick();                                   // E1: idx=1
        tick();                                   // E2: idx=2, bytes 0..1 written
        check("abort_partial", 64'(s), 64'h0000_3344);
        #3 reset_n = 1'b0;
        #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_s", 64'(s), 64'd0);
        check("abort_co", 64'(co), 64'd0);
        tick();
        #3 reset_n = 1'b1;
        done_cnt = 0;
        for (int w = 0; w < 8; w++) begin
            tick();
            if (done) done_cnt++;
        end
        check("abort_no_done", 64'(done_cnt), 64'd0);
        check("abort_idle_busy", 64'(busy), 64'd0);
        do_op("after_abort", 32'h0102_0304, 32'h1020_3040, 1'b0, 32'h1122_3344, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
